sgpio_rx_ctrl: RTL and testbench

SGPIO_RX_CTRL -- requirements
Module: sgpio_rx_ctrl

---
 rtl/sgpio_rx_ctrl.sv | 131 +++++++++++++
 tb/tb_sgpio_rx_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgpio_rx_ctrl.sv
// sgpio_rx_ctrl: SGPIO target receiver that decodes per-slot LED requests and returns drive presence on sdatain
module sgpio_rx_ctrl #(
  parameter int NUM_DRV     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sclock,
  input  logic               sload,
  input  logic               sdataout,
  input  logic [NUM_DRV-1:0] drive_present,
  output logic               sdatain,
  output logic [NUM_DRV-1:0] fault,
  output logic [NUM_DRV-1:0] active,
  output logic [NUM_DRV-1:0] locate,
  output logic [NUM_DRV-1:0] rebuild,
  output logic               frame_valid,
  output logic               link_up,
  output logic [7:0]         frame_err_cnt
);
  localparam int FW = 3 * NUM_DRV;
  localparam int CW = $clog2(FW + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  state_t state, state_n;
  logic [1:0] sclk_s, sload_s, sdo_s;
  logic sclk_d, rise, fall, timeout, last_bit;
  logic [CW-1:0] bit_cnt, tx_cnt;
  logic [FW-1:0] shadow;
  logic [FW:0] tx_vec;
  logic [WW-1:0] wd;
  logic [NUM_DRV-1:0] dec_act, dec_loc, dec_flt, dec_rbd;
  assign rise     = sclk_s[1] & ~sclk_d;
  assign fall     = ~sclk_s[1] & sclk_d;
  assign timeout  = (wd == WW'(TIMEOUT_CYC)) && !rise;
  assign last_bit = bit_cnt == CW'(FW - 1);
  // two-flop synchronizers on the host signals plus one history flop for sclock edges
  always_ff @(posedge clk)
    if (rst) begin
      sclk_s  <= '0;
      sload_s <= '0;
      sdo_s   <= '0;
      sclk_d  <= 1'b0;
    end else begin
      sclk_s  <= {sclk_s[0], sclock};
      sload_s <= {sload_s[0], sload};
      sdo_s   <= {sdo_s[0], sdataout};
      sclk_d  <= sclk_s[1];
    end
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state: timeout forces idle, LATCH is a single cycle, frames start on sload and end on the last bit
  always_comb begin
    state_n = state;
    if (timeout || state == LATCH) state_n = IDLE;
    else if (rise && state == IDLE && sload_s[1]) state_n = SHIFT;
    else if (rise && state == SHIFT && !sload_s[1] && last_bit) state_n = LATCH;
  end
  // shadow shift register; any sload rise (frame start or abort) clears it so partial data never survives
  always_ff @(posedge clk)
    if (rst || timeout) begin
      bit_cnt <= '0;
      shadow  <= '0;
    end else if (state == LATCH) begin
      bit_cnt <= '0;
    end else if (rise && sload_s[1]) begin
      bit_cnt <= '0;
      shadow  <= '0;
    end else if (rise && state == SHIFT) begin
      shadow[bit_cnt] <= sdo_s[1];
      bit_cnt         <= bit_cnt + CW'(1);
    end
  // saturating count of frames aborted by an early sload
  always_ff @(posedge clk)
    if (rst) frame_err_cnt <= '0;
    else if (rise && sload_s[1] && state == SHIFT && frame_err_cnt != 8'hff) frame_err_cnt <= frame_err_cnt + 8'd1;
  // slot decode of the shadow frame and the presence pattern returned to the host
  always_comb begin
    tx_vec  = '0;
    dec_act = '0;
    dec_loc = '0;
    dec_flt = '0;
    dec_rbd = '0;
    for (int i = 0; i < NUM_DRV; i++) begin
      tx_vec[3*i] = drive_present[i];
      dec_act[i]  = shadow[3*i] & drive_present[i];
      dec_rbd[i]  = shadow[3*i+1] & shadow[3*i+2];
      dec_loc[i]  = shadow[3*i+1] & ~shadow[3*i+2];
      dec_flt[i]  = shadow[3*i+2] & ~shadow[3*i+1];
    end
  end
  // LED outputs load only in LATCH and drop on link loss
  always_ff @(posedge clk)
    if (rst || timeout) begin
      active      <= '0;
      locate      <= '0;
      fault       <= '0;
      rebuild     <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= state == LATCH;
      if (state == LATCH) begin
        active  <= dec_act;
        locate  <= dec_loc;
        fault   <= dec_flt;
        rebuild <= dec_rbd;
      end
    end
  // watchdog: cleared by every sclock rise, saturates at the timeout value
  always_ff @(posedge clk)
    if (rst || rise) wd <= '0;
    else if (wd != WW'(TIMEOUT_CYC)) wd <= wd + WW'(1);
  // link status follows sclock activity
  always_ff @(posedge clk)
    if (rst) link_up <= 1'b0;
    else if (rise) link_up <= 1'b1;
    else if (timeout) link_up <= 1'b0;
  // sdatain transmit side, indexed independently of the receive counter; bit FW of tx_vec is the trailing zero
  always_ff @(posedge clk)
    if (rst) begin
      tx_cnt  <= '0;
      sdatain <= 1'b0;
    end else if (rise && sload_s[1]) begin
      tx_cnt <= '0;
    end else if (fall) begin
      sdatain <= tx_vec[tx_cnt];
      if (tx_cnt != CW'(FW)) tx_cnt <= tx_cnt + CW'(1);
    end
endmodule

// File: tb/tb_sgpio_rx_ctrl.sv
// tb_sgpio_rx_ctrl: randomized and directed checks of sgpio_rx_ctrl against a slot-level reference model
module tb_sgpio_rx_ctrl;
  localparam int N  = 4;
  localparam int FW = 3 * N;
  localparam int TO = 64;
  logic clk = 1'b0, rst = 1'b1, sclock = 1'b0, sload = 1'b0, sdataout = 1'b0;
  logic [N-1:0] drive_present = '1;
  logic sdatain, frame_valid, link_up;
  logic [N-1:0] fault, active, locate, rebuild;
  logic [7:0] frame_err_cnt;
  int total = 0, bad = 0, fv_count = 0, exp_err = 0;
  logic [4*N-1:0] last_exp = '0;
  always #5 clk = ~clk;
  sgpio_rx_ctrl #(.NUM_DRV(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .sclock(sclock), .sload(sload), .sdataout(sdataout),
    .drive_present(drive_present), .sdatain(sdatain), .fault(fault), .active(active),
    .locate(locate), .rebuild(rebuild), .frame_valid(frame_valid), .link_up(link_up),
    .frame_err_cnt(frame_err_cnt)
  );
  always @(negedge clk) if (frame_valid === 1'b1) fv_count++;
  function automatic logic [4*N-1:0] model(input logic [FW-1:0] bits, input logic [N-1:0] pres);
    logic [N-1:0] a, l, f, r;
    for (int i = 0; i < N; i++) begin
      a[i] = bits[3*i] && pres[i];
      if (bits[3*i+1] && bits[3*i+2]) begin
        r[i] = 1'b1; l[i] = 1'b0; f[i] = 1'b0;
      end else begin
        r[i] = 1'b0; l[i] = bits[3*i+1]; f[i] = bits[3*i+2];
      end
    end
    return {r, f, l, a};
  endfunction
  function automatic logic [FW-1:0] slot(input logic [FW-1:0] bits, input int i, input logic a, input logic l, input logic f);
    logic [FW-1:0] b;
    b = bits;
    b[3*i] = a; b[3*i+1] = l; b[3*i+2] = f;
    return b;
  endfunction
  task automatic sbit(input logic ld, input logic d, output logic sd);
    sload = ld;
    sdataout = d;
    repeat (4) @(negedge clk);
    sd = sdatain;
    sclock = 1'b1;
    repeat (4) @(negedge clk);
    sclock = 1'b0;
  endtask
  task automatic check_leds(input string tag, input logic [4*N-1:0] exp);
    total++;
    if ({rebuild, fault, locate, active} !== exp) begin
      bad++;
      $display("FAIL %s leds rbd/flt/loc/act got %h want %h", tag, {rebuild, fault, locate, active}, exp);
    end
  endtask
  task automatic send_frame(input string tag, input logic [FW-1:0] bits, output logic [FW-1:0] seq);
    logic sd;
    int fv0;
    fv0 = fv_count;
    sbit(1'b1, 1'b0, sd);
    for (int k = 0; k < FW - 1; k++) begin
      sbit(1'b0, bits[k], sd);
      seq[k] = sd;
    end
    sload = 1'b0;
    sdataout = bits[FW-1];
    repeat (4) @(negedge clk);
    seq[FW-1] = sdatain;
    sclock = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (frame_valid !== (c == 4)) begin
        bad++;
        $display("FAIL %s frame_valid clk %0d after last sclock rise got %b want %b", tag, c, frame_valid, c == 4);
      end
    end
    @(negedge clk);
    sclock = 1'b0;
    for (int k = 0; k < FW; k++) begin
      total++;
      if (seq[k] !== ((k % 3 == 0) ? drive_present[k/3] : 1'b0)) begin
        bad++;
        $display("FAIL %s sdatain bit %0d got %b want %b", tag, k, seq[k], (k % 3 == 0) ? drive_present[k/3] : 1'b0);
      end
    end
    last_exp = model(bits, drive_present);
    check_leds(tag, last_exp);
    total++;
    if (fv_count !== fv0 + 1) begin
      bad++;
      $display("FAIL %s frame_valid pulses got %0d want 1", tag, fv_count - fv0);
    end
    total++;
    if (link_up !== 1'b1 || frame_err_cnt !== 8'(exp_err)) begin
      bad++;
      $display("FAIL %s link_up/err got %b/%0d want 1/%0d", tag, link_up, frame_err_cnt, exp_err);
    end
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    check_leds("reset", '0);
    total++;
    if ({frame_valid, link_up, sdatain, frame_err_cnt} !== 11'd0) begin
      bad++;
      $display("FAIL reset fv/link/sdi/err got %b%b%b/%0d want 000/0", frame_valid, link_up, sdatain, frame_err_cnt);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_basic;
    logic [FW-1:0] b, seq;
    drive_present = 4'b1111;
    b = slot('0, 0, 1'b1, 1'b0, 1'b0);
    b = slot(b, 2, 1'b0, 1'b0, 1'b1);
    send_frame("basic", b, seq);
    total++;
    if (active !== 4'b0001 || fault !== 4'b0100 || locate !== 4'b0000 || rebuild !== 4'b0000) begin
      bad++;
      $display("FAIL basic_const act/flt/loc/rbd got %b/%b/%b/%b want 0001/0100/0000/0000", active, fault, locate, rebuild);
    end
  endtask
  task automatic test_rebuild;
    logic [FW-1:0] seq;
    send_frame("rebuild", slot('0, 2, 1'b0, 1'b1, 1'b1), seq);
    total++;
    if (rebuild[2] !== 1'b1 || locate[2] !== 1'b0 || fault[2] !== 1'b0) begin
      bad++;
      $display("FAIL rebuild_slot2 rbd/loc/flt got %b%b%b want 100", rebuild[2], locate[2], fault[2]);
    end
  endtask
  task automatic test_presence;
    logic [FW-1:0] seq;
    drive_present = 4'b1101;
    send_frame("presence", slot(slot('0, 1, 1'b1, 1'b0, 1'b0), 0, 1'b1, 1'b0, 1'b0), seq);
    total++;
    if (active !== 4'b0001) begin
      bad++;
      $display("FAIL presence active got %b want 0001", active);
    end
  endtask
  task automatic test_sdatain;
    logic [FW-1:0] seq;
    logic [FW-1:0] want;
    want = 12'b0010_0000_1000;
    drive_present = 4'b1010;
    send_frame("sdatain", 12'h5a5, seq);
    total++;
    if (seq !== want) begin
      bad++;
      $display("FAIL sdatain_seq got %b want %b (bit0 rightmost)", seq, want);
    end
  endtask
  task automatic test_random;
    logic [FW-1:0] seq;
    for (int n = 0; n < 15; n++) begin
      drive_present = N'($urandom);
      send_frame("random", FW'($urandom), seq);
    end
  endtask
  task automatic test_abort;
    logic sd;
    logic [FW-1:0] seq;
    int fv0;
    fv0 = fv_count;
    drive_present = 4'b1111;
    sbit(1'b1, 1'b0, sd);
    for (int k = 0; k < 7; k++) sbit(1'b0, 1'($urandom), sd);
    exp_err = exp_err + 1;
    send_frame("abort_then_full", FW'($urandom) | 12'h001, seq);
    total++;
    if (fv_count !== fv0 + 1 || frame_err_cnt !== 8'd1) begin
      bad++;
      $display("FAIL abort pulses/err got %0d/%0d want 1/1", fv_count - fv0, frame_err_cnt);
    end
  endtask
  task automatic test_timeout;
    logic sd;
    logic [FW-1:0] seq;
    drive_present = 4'b1111;
    send_frame("pre_timeout", 12'b111_011_001_101, seq);
    repeat (TO - 20) @(negedge clk);
    total++;
    if (link_up !== 1'b1) begin
      bad++;
      $display("FAIL timeout_early link_up got %b want 1", link_up);
    end
    check_leds("timeout_early", last_exp);
    repeat (30) @(negedge clk);
    total++;
    if (link_up !== 1'b0 || frame_err_cnt !== 8'(exp_err)) begin
      bad++;
      $display("FAIL timeout link_up/err got %b/%0d want 0/%0d", link_up, frame_err_cnt, exp_err);
    end
    check_leds("timeout", '0);
    sbit(1'b0, 1'b1, sd);
    total++;
    if (link_up !== 1'b1) begin
      bad++;
      $display("FAIL relink link_up got %b want 1", link_up);
    end
    check_leds("relink", '0);
  endtask
  task automatic test_timeout_mid;
    logic sd;
    logic [FW-1:0] seq;
    int fv0;
    fv0 = fv_count;
    sbit(1'b1, 1'b0, sd);
    for (int k = 0; k < 5; k++) sbit(1'b0, 1'b1, sd);
    repeat (TO + 10) @(negedge clk);
    for (int k = 0; k < 7; k++) sbit(1'b0, 1'b1, sd);
    total++;
    if (fv_count !== fv0 || link_up !== 1'b1) begin
      bad++;
      $display("FAIL timeout_mid pulses/link got %0d/%b want 0/1", fv_count - fv0, link_up);
    end
    check_leds("timeout_mid", '0);
    send_frame("after_timeout", FW'($urandom), seq);
  endtask
  task automatic test_err_saturate;
    logic sd;
    int fv0;
    fv0 = fv_count;
    for (int n = 0; n < 260; n++) begin
      sbit(1'b1, 1'b0, sd);
      if (n > 0) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    end
    total++;
    if (frame_err_cnt !== 8'(exp_err) || exp_err != 255 || fv_count !== fv0) begin
      bad++;
      $display("FAIL err_saturate err/pulses got %0d/%0d want 255/0", frame_err_cnt, fv_count - fv0);
    end
  endtask
  task automatic test_reset_mid;
    logic sd;
    logic [FW-1:0] seq;
    int fv0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_err = 0;
    drive_present = 4'b1010;
    send_frame("pre_rst", 12'b101_110_011_111, seq);
    fv0 = fv_count;
    sbit(1'b1, 1'b0, sd);
    for (int k = 0; k < 5; k++) sbit(1'b0, 1'b1, sd);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_leds("rst_mid", '0);
    total++;
    if ({frame_valid, link_up, sdatain, frame_err_cnt} !== 11'd0) begin
      bad++;
      $display("FAIL rst_mid fv/link/sdi/err got %b%b%b/%0d want 000/0", frame_valid, link_up, sdatain, frame_err_cnt);
    end
    for (int k = 0; k < 7; k++) sbit(1'b0, 1'b1, sd);
    repeat (6) @(negedge clk);
    check_leds("rst_mid_tail", '0);
    total++;
    if (fv_count !== fv0 || frame_err_cnt !== 8'd0) begin
      bad++;
      $display("FAIL rst_mid_tail pulses/err got %0d/%0d want 0/0", fv_count - fv0, frame_err_cnt);
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_rebuild;
    test_presence;
    test_sdatain;
    test_random;
    test_abort;
    test_timeout;
    test_timeout_mid;
    test_err_saturate;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
